router_pkt_fifo: RTL

ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

---
 rtl/router_pkg.sv | 13 +
 rtl/router_pkt_tracker.sv | 39 +++
 rtl/router_pkt_fifo.sv | 87 ++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router packet FIFO slice.
package router_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 16;
  // Header byte carries the payload length in [DATA_W-1:HDR_LEN_LSB]
  localparam int HDR_LEN_LSB = 2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_pkt_tracker.sv
// Read-side packet length tracker: flags header and parity (last) bytes on data_out.
module router_pkt_tracker
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          soft_reset,
  input  logic                          rd_ok,
  input  logic                          rd_hdr,
  input  logic [DATA_W-1-HDR_LEN_LSB:0] hdr_len,
  output logic                          rd_sof,
  output logic                          rd_eof
);

  localparam int RW = DATA_W - 1;

  logic [RW-1:0] rem;

  // A header always reloads rem, so a truncated packet never emits its eof
  always_ff @(posedge clk) begin
    if (!resetn || soft_reset) begin
      rem    <= '0;
      rd_sof <= 1'b0;
      rd_eof <= 1'b0;
    end else begin
      rd_sof <= rd_ok && rd_hdr;
      rd_eof <= rd_ok && !rd_hdr && (rem == RW'(1));
      if (rd_ok) begin
        if (rd_hdr)
          rem <= RW'(hdr_len) + RW'(1);
        else if (rem != '0)
          rem <= rem - RW'(1);
      end
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Router packet FIFO: wrap-bit pointer storage with header tagging and registered read port.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      soft_reset,
  input  logic                      write_enb,
  input  logic                      lfd_state,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      read_enb,
  output logic [DATA_W-1:0]         data_out,
  output logic                      dout_valid,
  output logic                      rd_sof,
  output logic                      rd_eof,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      wr_ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

  logic [DATA_W:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              lfd_q;
  logic              run, wr_ok, rd_ok;
  logic [DATA_W:0]   rd_entry;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_THR);

  // Flags are pre-edge, so read+write on full/empty degrades to read-only/write-only
  assign run      = resetn && !soft_reset;
  assign wr_ok    = run && write_enb && !full;
  assign rd_ok    = run && read_enb && !empty;
  assign rd_entry = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr[PW-2:0]] <= {lfd_q, data_in};
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lfd_q      <= 1'b0;
      wr_ovf     <= 1'b0;
      data_out   <= '0;
      dout_valid <= 1'b0;
    end else begin
      lfd_q      <= lfd_state;
      dout_valid <= rd_ok;
      if (write_enb && full)
        wr_ovf <= 1'b1;
      if (wr_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + PW'(1);
        data_out <= rd_entry[DATA_W-1:0];
      end
    end
  end

  router_pkt_tracker #(
    .DATA_W (DATA_W)
  ) u_tracker (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .rd_ok      (rd_ok),
    .rd_hdr     (rd_entry[DATA_W]),
    .hdr_len    (rd_entry[DATA_W-1:HDR_LEN_LSB]),
    .rd_sof     (rd_sof),
    .rd_eof     (rd_eof)
  );

endmodule
